mag_sar_search: RTL



---
 rtl/mag_sar_search_if.sv | 24 ++
 rtl/mag_sar_search.sv | 100 ++++++++++
 2 files changed

// File: rtl/mag_sar_search_if.sv
// rtl/mag_sar_search_if.sv - search engine to comparator and requester signal bundle
interface mag_sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] probe;
    logic             cmp_e;
    logic             cmp_g;
    logic             cmp_l;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        input  start, cmp_e, cmp_g, cmp_l,
        output probe, busy, done, result, err
    );

    modport slave (
        output start, cmp_e, cmp_g, cmp_l,
        input  probe, busy, done, result, err
    );
endinterface

// File: rtl/mag_sar_search.sv
// rtl/mag_sar_search.sv - successive-approximation search against an external magnitude comparator
module mag_sar_search #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mag_sar_search_if.master  bus
);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] mask, mask_n;
    logic [WIDTH-1:0] probe, probe_n;
    logic [WIDTH-1:0] result, result_n;
    logic             err, err_n;
    logic [WIDTH-1:0] acc_upd;
    logic             flags_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mask   <= '0;
            probe  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            mask   <= mask_n;
            probe  <= probe_n;
            result <= result_n;
            err    <= err_n;
        end
    end

    // Exactly one of the three flags must be high for a trustworthy comparison
    assign flags_ok = ( bus.cmp_e & ~bus.cmp_g & ~bus.cmp_l) |
                      (~bus.cmp_e &  bus.cmp_g & ~bus.cmp_l) |
                      (~bus.cmp_e & ~bus.cmp_g &  bus.cmp_l);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mask_n   = mask;
        probe_n  = probe;
        result_n = result;
        err_n    = err;
        acc_upd  = bus.cmp_g ? probe : acc;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_n    = '0;
                    mask_n   = MSB;
                    probe_n  = MSB;
                    result_n = '0;
                    err_n    = 1'b0;
                    state_n  = SEARCH;
                end
            end
            SEARCH: begin
                if (!flags_ok) begin
                    err_n    = 1'b1;
                    result_n = '0;
                    probe_n  = '0;
                    state_n  = DONE;
                end else if (bus.cmp_e) begin
                    result_n = probe;
                    probe_n  = '0;
                    state_n  = DONE;
                end else if (mask[0]) begin
                    acc_n    = acc_upd;
                    result_n = acc_upd;
                    probe_n  = '0;
                    state_n  = DONE;
                end else begin
                    acc_n    = acc_upd;
                    mask_n   = mask >> 1;
                    probe_n  = acc_upd | (mask >> 1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.probe  = probe;
    assign bus.busy   = (state == SEARCH);
    assign bus.done   = (state == DONE);
    assign bus.result = result;
    assign bus.err    = err;
endmodule
